// File: rtl/req_arbiter_if.sv
// Requester-bank / responder bundle for req_arbiter: requests, keys, acks and grant status.
// Latency: none; pure signal grouping.
// Backpressure: none here; the arbiter's slave side holds each grant until down_ack arrives.
interface req_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int KEY_W = 4
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*KEY_W-1:0] req_key;
  logic [N_REQ-1:0]       ack;
  logic                   down_req;
  logic [KEY_W-1:0]       down_key;
  logic                   down_ack;
  logic [IDX_W-1:0]       grant_id;
  logic                   busy;
  logic                   timeout_err;

  // Drives requests/keys and plays the responder.
  modport master (
    output req, req_key, down_ack,
    input  ack, down_req, down_key, grant_id, busy, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  req, req_key, down_ack,
    output ack, down_req, down_key, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/req_arbiter.sv
// Round-robin arbiter sharing one req/ack responder among N_REQ key-issuing requesters.
// Latency: grant 1 cycle after req seen in IDLE; ack is combinational from down_ack; >=1 IDLE cycle between transactions.
// Backpressure: one outstanding transaction; BUSY holds until down_ack (or TIMEOUT_CYCLES when ARB_TIMEOUT_EN is defined).
module req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int KEY_W          = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  req_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  // Elaboration-time parameter sanity.
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("req_arbiter: N_REQ must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("req_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  // State: busy doubles as the FSM state bit (0 = IDLE, 1 = BUSY).
  logic             busy_q;
  logic [IDX_W-1:0] grant_id_q;
  logic [KEY_W-1:0] down_key_q;
  logic [IDX_W-1:0] rr_ptr_q;

  // Arbitration intermediates.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   rot_off;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W-1:0]   pick_id;
  logic               pick_vld;
  logic [KEY_W-1:0]   pick_key;

  logic               done;
  logic               abort;
  logic [IDX_W-1:0]   next_ptr;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl  = {bus.req, bus.req};
    req_rot  = req_dbl[rr_ptr_q +: N_REQ];
    rot_off  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rot_off = IDX_W'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, rot_off};
    if (pick_sum >= (IDX_W + 1)'(N_REQ)) begin
      pick_sum = pick_sum - (IDX_W + 1)'(N_REQ);
    end
    pick_id  = pick_sum[IDX_W-1:0];
    pick_vld = |bus.req;
    pick_key = bus.req_key[pick_id*KEY_W +: KEY_W];
  end

  // After serving grant_id, the next search starts just above it so it becomes lowest priority.
  assign next_ptr = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // A transaction ends on a real ack, or on the abort path when the watchdog is built in.
  assign done = busy_q && bus.down_ack;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;

  // Count ack-less BUSY cycles; cleared while IDLE so it starts at 0 on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (!busy_q) begin
      wait_cnt_q <= '0;
    end else if (!bus.down_ack) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // The TIMEOUT_CYCLES-th BUSY cycle without ack aborts; an ack in that same cycle wins.
  assign abort = busy_q && !bus.down_ack && (wait_cnt_q == CNT_LAST);
`else
  assign abort = 1'b0;
`endif

  // IDLE: grant and latch the winner's key. BUSY: hold until ack/abort, then advance rr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      grant_id_q <= '0;
      down_key_q <= '0;
      rr_ptr_q   <= '0;
    end else if (!busy_q) begin
      if (pick_vld) begin
        busy_q     <= 1'b1;
        grant_id_q <= pick_id;
        down_key_q <= pick_key;
      end
    end else if (done || abort) begin
      busy_q   <= 1'b0;
      rr_ptr_q <= next_ptr;
    end
  end

  // Route the responder's ack to the owner only; nothing leaks out while IDLE.
  always_comb begin
    bus.ack = '0;
    if (done) begin
      bus.ack[grant_id_q] = 1'b1;
    end
  end

  assign bus.down_req    = busy_q;
  assign bus.busy        = busy_q;
  assign bus.down_key    = down_key_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = abort;

  // Ack is at most one-hot.
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.ack));

  // Ack never appears without an outstanding transaction.
  a_ack_needs_busy: assert property (@(posedge clk) disable iff (!rst_n) (|bus.ack) |-> busy_q);

  // Owner and key are frozen for the whole BUSY period.
  a_grant_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (busy_q && !done && !abort) |=> (busy_q && $stable(grant_id_q) && $stable(down_key_q)));

  // Every transaction is followed by at least one IDLE cycle.
  a_gap: assert property (@(posedge clk) disable iff (!rst_n) (done || abort) |=> !busy_q);

  // Error pulse and ack are mutually exclusive.
  a_err_vs_ack: assert property (@(posedge clk) disable iff (!rst_n) !(abort && (|bus.ack)));

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Round-robin arbiter that shares a single downstream request/acknowledge responder among N_REQ requesters of the `req`/`req_key`/`ack` type. Each requester's key is latched at grant and forwarded downstream, and the downstream `ack` is routed back to the owning requester only. It sits between a bank of key-issuing requesters and one responder, enforcing one outstanding transaction at a time.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `KEY_W`, default 4: key width in bits.
- `TIMEOUT_CYCLES`, default 15: abort threshold in cycles; used only when `ARB_TIMEOUT_EN` is defined; must be ≥1.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request.
- `req_key`  in  N_REQ*KEY_W  packed keys; requester i occupies bits [i*KEY_W +: KEY_W].
- `ack`  out  N_REQ  per-requester acknowledge; one-hot or zero.
- `down_req`  out  1  request to the responder.
- `down_key`  out  KEY_W  latched key of the granted requester.
- `down_ack`  in  1  acknowledge from the responder.
- `grant_id`  out  $clog2(N_REQ)  index of the current owner; valid while `busy`.
- `busy`  out  1  transaction outstanding.
- `timeout_err`  out  1  one-cycle pulse on abort; tied to 0 without `ARB_TIMEOUT_EN`.

## Operation

**States**
- IDLE: no transaction is outstanding.
- BUSY: a transaction is in flight.
- The state is encoded in `busy`.

**IDLE**
- If any `req` bit is set, pick the first set bit at or after `rr_ptr`, searching upward with wrap from N_REQ-1 to 0.
- Register `grant_id`, latch that requester's `req_key` into `down_key`, and go to BUSY.
- If no `req` bit is set, stay in IDLE.

**BUSY**
- `down_req` = 1.
- When `down_ack` = 1:
  - `ack[grant_id]` = 1 in the same cycle (combinational from `down_ack` and state).
  - Next cycle: go to IDLE and set `rr_ptr` = (`grant_id`+1) mod N_REQ.

**Masking and stability**
- `ack` is 0 in IDLE.
- `down_ack` in IDLE is ignored; it produces no `ack` and no state change.
- Keys are sampled only at grant. `down_key` and `grant_id` are held constant for the whole BUSY period, even if the owner changes its key or drops `req`.
- There is no cancellation: a dropped `req` during BUSY does not end the transaction.

**Fairness**
- After requester i is served, i has the lowest priority.
- Any continuously asserting requester is granted within N_REQ transactions.

**Reset values**
- `busy` = 0, `down_req` = 0, `down_key` = 0, `grant_id` = 0, `rr_ptr` = 0, `ack` = 0, `timeout_err` = 0.
- Reset asserted mid-transaction drops `down_req` and `ack` immediately (asynchronous), and the in-flight transaction is discarded.

## Timing
- Grant latency: `req` seen in IDLE at edge t gives `down_req` = 1 from cycle t+1.
- Acknowledge path: zero-cycle, combinational from `down_ack` to `ack`.
- Gap between transactions: at least one IDLE cycle between back-to-back transactions. `down_req` falls for exactly one cycle after `down_ack` even when requests are pending.
- Throughput: at most one transaction per 2 cycles, reached when the responder acks on the first BUSY cycle.
- Simultaneous `down_ack` and reset deassertion: reset wins; no `ack` is issued.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to BUSY and increments on every BUSY cycle without `down_ack`.
  - When the count reaches `TIMEOUT_CYCLES` without `down_ack`, the block pulses `timeout_err` for 1 cycle, returns to IDLE with no `ack`, and advances `rr_ptr` past `grant_id`.
  - `down_ack` arriving in the same cycle as the threshold takes priority: normal `ack` is issued and there is no error.
- **Undefined:**
  - No counter logic is present and `timeout_err` = 0.
  - BUSY lasts indefinitely until `down_ack`.

## Test plan
- **Reset:** hold `rst_n` = 0 with `req` = 4'b1111.
  - All outputs 0.
  - Release → `grant_id` = 0, `busy` = 1 one cycle later.
- **Single requester:** only `req[2]` = 1 with key 4'hA, `down_ack` on the 3rd BUSY cycle.
  - `down_key` = 4'hA.
  - `ack` = 4'b0100 for exactly 1 cycle.
  - `busy` = 0 next cycle.
- **Round robin:** `req` = 4'b1111, responder acks on the first BUSY cycle.
  - Grant order 0,1,2,3,0.
  - `down_req` pattern 1,0,1,0,…
- **Key stability:** change `req_key[1]` from 4'h3 to 4'h7 mid-BUSY.
  - `down_key` stays 4'h3 until `ack[1]`.
- **Stray and reset edges:**
  - `down_ack` = 1 in IDLE → no `ack`, no grant change.
  - `rst_n` low mid-BUSY → `down_req` = 0 immediately, `rr_ptr` = 0.
- **Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 15):** no `down_ack`.
  - `timeout_err` pulses at BUSY cycle 15.
  - No `ack`.
  - Next grant goes to the next pending requester.
  - A second run with `down_ack` on cycle 15 → normal `ack`, no error.
